// File: rtl/ask_tx.sv
// ASK frame serializer: preamble (1 bit/clk), then syncword and payload bytes (1 symbol per SYMBCLK_PRESCALER clks), BYTE_GAP zero symbols after each byte.
// Latency: first preamble bit appears on serialout the clk after the accepting transfer; serialout is registered.
// Backpressure: tx_ready is high in IDLE, and during SYNC/DATA/GAP while the one-deep next buffer is empty and no last byte was taken.
//
// Ports:
//   clk        system clock, all logic on posedge
//   reset      asynchronous active-low reset
//   tx_data    payload byte, sampled only on a transfer (tx_valid & tx_ready)
//   tx_valid   tx_data/tx_last valid
//   tx_last    byte closes the frame
//   tx_ready   byte accepted this cycle when tx_valid is high
//   serialout  registered on-air bit stream
//   busy       frame in progress
//   done       one-clk pulse after the final gap of a frame
//   underrun   one-clk pulse when a frame ends because no next byte arrived in time
module ask_tx #(
    parameter int                        PREAMBLE_WIDTH    = 32,
    parameter logic [PREAMBLE_WIDTH-1:0] PREAMBLE          = 32'hF0F0F0F0,
    parameter int                        SYNCWORD_WIDTH    = 8,
    parameter logic [SYNCWORD_WIDTH-1:0] SYNCWORD          = 8'b11100101,
    parameter int                        SYMBCLK_PRESCALER = 4,
    parameter int                        PACKLEN           = 8,
    parameter int                        BYTE_GAP          = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PACKLEN-1:0] tx_data,
    input  logic               tx_valid,
    input  logic               tx_last,
    output logic               tx_ready,
    output logic               serialout,
    output logic               busy,
    output logic               done,
    output logic               underrun
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_SYNC = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;

    localparam int LEN_A  = (PREAMBLE_WIDTH > SYNCWORD_WIDTH) ? PREAMBLE_WIDTH : SYNCWORD_WIDTH;
    localparam int LEN_B  = (PACKLEN > BYTE_GAP) ? PACKLEN : BYTE_GAP;
    localparam int MAXLEN = (LEN_A > LEN_B) ? LEN_A : LEN_B;
    localparam int CNT_W  = $clog2(MAXLEN) + 1;
    localparam int SYM_W  = $clog2(SYMBCLK_PRESCALER) + 1;

    logic [2:0]         state, state_n;
    logic [CNT_W-1:0]   bit_idx, bit_n;
    logic [SYM_W-1:0]   sym_cnt, sym_n;
    logic [PACKLEN-1:0] cur_byte, cur_n;
    logic               cur_last, cur_last_n;
    logic [PACKLEN-1:0] nxt_byte, nxt_byte_n;
    logic               nxt_last, nxt_last_n;
    logic               nxt_full, nxt_full_n;
    logic               last_taken, last_taken_n;
    logic               done_n, underrun_n;
    logic               line_n;

    logic               xfer;
    logic               sym_state;
    logic               sym_wrap;
    logic               seg_end;
    logic [CNT_W-1:0]   seg_last;

    logic [PREAMBLE_WIDTH-1:0] pre_sh;
    logic [SYNCWORD_WIDTH-1:0] sync_sh;
    logic [PACKLEN-1:0]        data_sh;

    assign sym_state = (state == ST_SYNC) || (state == ST_DATA) || (state == ST_GAP);
    // Gated by reset so the host sees no ready while the block is held in reset.
    assign tx_ready  = reset & ((state == ST_IDLE) | (sym_state & ~nxt_full & ~last_taken));
    assign xfer      = tx_valid & tx_ready;
    assign busy      = (state != ST_IDLE);
    assign sym_wrap  = (sym_cnt == SYM_W'(SYMBCLK_PRESCALER - 1));

    always_comb begin
        seg_last = '0;
        case (state)
            ST_SYNC: seg_last = CNT_W'(SYNCWORD_WIDTH - 1);
            ST_DATA: seg_last = CNT_W'(PACKLEN - 1);
            ST_GAP:  seg_last = CNT_W'(BYTE_GAP - 1);
            default: seg_last = '0;
        endcase
    end

    assign seg_end = sym_state & sym_wrap & (bit_idx == seg_last);

    always_comb begin
        state_n      = state;
        bit_n        = bit_idx;
        sym_n        = sym_cnt;
        cur_n        = cur_byte;
        cur_last_n   = cur_last;
        nxt_byte_n   = nxt_byte;
        nxt_last_n   = nxt_last;
        nxt_full_n   = nxt_full;
        last_taken_n = last_taken;
        done_n       = 1'b0;
        underrun_n   = 1'b0;

        // Any transfer outside IDLE lands in the next buffer; the GAP exit
        // below may instead route it straight into the current register.
        if (xfer && (state != ST_IDLE)) begin
            nxt_full_n   = 1'b1;
            nxt_byte_n   = tx_data;
            nxt_last_n   = tx_last;
            last_taken_n = last_taken | tx_last;
        end

        // Symbol-rate counters shared by SYNC, DATA and GAP.
        if (sym_state) begin
            if (sym_wrap) begin
                sym_n = '0;
                bit_n = seg_end ? '0 : bit_idx + CNT_W'(1);
            end else begin
                sym_n = sym_cnt + SYM_W'(1);
            end
        end

        case (state)
            ST_IDLE: begin
                if (xfer) begin
                    state_n      = ST_PRE;
                    bit_n        = '0;
                    sym_n        = '0;
                    cur_n        = tx_data;
                    cur_last_n   = tx_last;
                    last_taken_n = tx_last;
                    nxt_full_n   = 1'b0;
                end
            end
            ST_PRE: begin
                if (bit_idx == CNT_W'(PREAMBLE_WIDTH - 1)) begin
                    state_n = ST_SYNC;
                    bit_n   = '0;
                    sym_n   = '0;
                end else begin
                    bit_n = bit_idx + CNT_W'(1);
                end
            end
            ST_SYNC: if (seg_end) state_n = ST_DATA;
            ST_DATA: if (seg_end) state_n = ST_GAP;
            ST_GAP: begin
                if (seg_end) begin
                    if (cur_last) begin
                        state_n      = ST_IDLE;
                        done_n       = 1'b1;
                        last_taken_n = 1'b0;
                        nxt_full_n   = 1'b0;
                    end else if (nxt_full) begin
                        state_n    = ST_DATA;
                        cur_n      = nxt_byte;
                        cur_last_n = nxt_last;
                        nxt_full_n = 1'b0;
                    end else if (xfer) begin
                        // Byte arriving on the last gap clk goes directly to DATA.
                        state_n    = ST_DATA;
                        cur_n      = tx_data;
                        cur_last_n = tx_last;
                        nxt_full_n = 1'b0;
                    end else begin
                        state_n      = ST_IDLE;
                        underrun_n   = 1'b1;
                        last_taken_n = 1'b0;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                bit_n   = '0;
                sym_n   = '0;
            end
        endcase
    end

    // serialout is computed from next-state values so the line is registered
    // yet shows the first preamble bit one clk after the accepting transfer.
    always_comb begin
        pre_sh  = PREAMBLE << bit_n;
        sync_sh = SYNCWORD << bit_n;
        data_sh = cur_n << bit_n;
        line_n  = 1'b0;
        case (state_n)
            ST_PRE:  line_n = pre_sh[PREAMBLE_WIDTH-1];
            ST_SYNC: line_n = sync_sh[SYNCWORD_WIDTH-1];
            ST_DATA: line_n = data_sh[PACKLEN-1];
            default: line_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            bit_idx    <= '0;
            sym_cnt    <= '0;
            cur_byte   <= '0;
            cur_last   <= 1'b0;
            nxt_byte   <= '0;
            nxt_last   <= 1'b0;
            nxt_full   <= 1'b0;
            last_taken <= 1'b0;
            serialout  <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_n;
            bit_idx    <= bit_n;
            sym_cnt    <= sym_n;
            cur_byte   <= cur_n;
            cur_last   <= cur_last_n;
            nxt_byte   <= nxt_byte_n;
            nxt_last   <= nxt_last_n;
            nxt_full   <= nxt_full_n;
            last_taken <= last_taken_n;
            serialout  <= line_n;
            done       <= done_n;
            underrun   <= underrun_n;
        end
    end

endmodule

// File: tb/tb_ask_tx.sv
// Bench for ask_tx: directed frames plus randomized byte offer schedules,
// compared cycle by cycle against a frame-timeline reference model.
module tb_ask_tx;

    localparam int PW    = 32;
    localparam int SW    = 8;
    localparam int P     = 4;
    localparam int PL    = 8;
    localparam int BG    = 1;
    localparam int SYMPB = P * (PL + BG);
    localparam int MAXC  = 1500;
    localparam int MAXN  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       serialout;
    logic       busy;
    logic       done;
    logic       underrun;

    always #5 clk = ~clk;

    ask_tx #(
        .PREAMBLE_WIDTH   (PW),
        .PREAMBLE         (32'hF0F0F0F0),
        .SYNCWORD_WIDTH   (SW),
        .SYNCWORD         (8'b11100101),
        .SYMBCLK_PRESCALER(P),
        .PACKLEN          (PL),
        .BYTE_GAP         (BG)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .serialout(serialout),
        .busy     (busy),
        .done     (done),
        .underrun (underrun)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [3:0] exp_vec [MAXC];   // {serialout, busy, done, underrun} per cycle
    int         exp_acc [MAXN];
    int         acc_act [MAXN];
    int         offer   [MAXN];
    logic [7:0] pay     [MAXN];
    int         run_len;
    logic [31:0] pre_v  = 32'hF0F0F0F0;
    logic [7:0]  sync_v = 8'b11100101;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, want);
    endtask

    task automatic put(input int c, input logic b);
        if (c < MAXC) exp_vec[c] = {b, 1'b1, 2'b00};
    endtask

    // Lays one frame (accepted at cycle s, bytes pay[fj..fj+cnt-1]) onto the
    // expected timeline, followed by its done or underrun pulse.
    task automatic emit_frame(input int s, input int fj, input int cnt, input bit is_done);
        int c;
        logic [7:0] v;
        c = s + 1;
        for (int i = 0; i < PW; i++) begin put(c, pre_v[PW-1-i]); c++; end
        for (int i = 0; i < SW; i++)
            for (int r = 0; r < P; r++) begin put(c, sync_v[SW-1-i]); c++; end
        for (int b = 0; b < cnt; b++) begin
            v = pay[fj+b];
            for (int i = 0; i < PL; i++)
                for (int r = 0; r < P; r++) begin put(c, v[PL-1-i]); c++; end
            for (int i = 0; i < BG * P; i++) begin put(c, 1'b0); c++; end
        end
        if (c < MAXC) exp_vec[c] = is_done ? 4'b0010 : 4'b0001;
        if (c + 4 > run_len) run_len = c + 4;
        if (run_len > MAXC) run_len = MAXC;
    endtask

    // Reference: byte k of a frame starting at s has its first DATA clk at
    // s+1+PW+P*SW+k*SYMPB; the next byte must be taken before that clk, and
    // can only be taken once SYNC begins and the previous byte left the buffer.
    task automatic model(input int n);
        int s, k, fj, acc_prev, idle_from, eo, a, t_next, ws, d_base;
        for (int t = 0; t < MAXC; t++) exp_vec[t] = 4'b0000;
        run_len = 0;
        s = 0; k = 0; fj = 0; acc_prev = -1; idle_from = 0;
        d_base = 1 + PW + P * SW;
        for (int j = 0; j < n; j++) begin
            eo = (offer[j] > acc_prev + 1) ? offer[j] : acc_prev + 1;
            if (k == 0) begin
                a = (eo > idle_from) ? eo : idle_from;
                s = a; fj = j; k = 1;
            end else begin
                t_next = s + d_base + k * SYMPB;
                ws = (k == 1) ? s + PW + 1 : s + d_base + (k - 1) * SYMPB;
                if (ws < acc_prev + 1) ws = acc_prev + 1;
                a = (eo > ws) ? eo : ws;
                if (a < t_next) begin
                    k++;
                end else begin
                    emit_frame(s, fj, k, 1'b0);
                    idle_from = t_next;
                    a = (eo > t_next) ? eo : t_next;
                    s = a; fj = j; k = 1;
                end
            end
            exp_acc[j] = a;
            acc_prev   = a;
        end
        emit_frame(s, fj, k, 1'b1);
    endtask

    // Entered #1 after a posedge with the DUT idle; cycle 0 is this cycle.
    task automatic run_scn(input int n);
        int j;
        model(n);
        for (int i = 0; i < MAXN; i++) acc_act[i] = -1;
        j = 0;
        for (int c = 0; c < run_len; c++) begin
            if (j < n && c >= offer[j]) begin
                tx_valid = 1'b1;
                tx_data  = pay[j];
                tx_last  = (j == n - 1);
            end else begin
                tx_valid = 1'b0;
                tx_data  = 8'($urandom);
                tx_last  = 1'($urandom);
            end
            @(negedge clk);
            chk($sformatf("line/busy/done/underrun@%0d", c),
                {28'd0, serialout, busy, done, underrun}, {28'd0, exp_vec[c]});
            if (tx_valid && tx_ready && j < n) begin
                acc_act[j] = c;
                j++;
            end
            @(posedge clk);
            #1;
        end
        tx_valid = 1'b0;
        for (int i = 0; i < n; i++)
            chk($sformatf("accept_cycle[%0d]", i), acc_act[i], exp_acc[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n, d;
        reset    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_last  = 1'b0;
        #2;
        chk("reset_outputs", {27'd0, serialout, busy, done, underrun, tx_ready}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("idle_ready", {31'd0, tx_ready}, 32'd1);

        // Single byte 0xA5: 100-clk frame, done right after.
        pay[0] = 8'hA5; offer[0] = 0;
        run_scn(1);

        // Three bytes with valid held high.
        pay[0] = 8'h01; pay[1] = 8'hFF; pay[2] = 8'h80;
        offer[0] = 0; offer[1] = 0; offer[2] = 0;
        run_scn(3);

        // Second byte one clk too late: underrun, then a new frame.
        pay[0] = 8'hA1; pay[1] = 8'h5E; offer[0] = 0; offer[1] = 101;
        run_scn(2);

        // Second byte exactly on the final gap clk: seamless continuation.
        pay[0] = 8'hC3; pay[1] = 8'h3C; offer[0] = 0; offer[1] = 100;
        run_scn(2);

        pay[0] = 8'h3C; offer[0] = 0;
        run_scn(1);

        // Asynchronous reset in the middle of SYNC.
        tx_valid = 1'b1; tx_data = 8'h55; tx_last = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (39) @(posedge clk);
        #2;
        chk("busy_before_reset", {31'd0, busy}, 32'd1);
        reset = 1'b0; tx_valid = 1'b1;
        #1;
        chk("mid_reset_outputs", {27'd0, serialout, busy, done, underrun, tx_ready}, 32'd0);
        @(posedge clk); #1;
        chk("held_reset_outputs", {27'd0, serialout, busy, done, underrun, tx_ready}, 32'd0);
        tx_valid = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post_reset_idle%0d", i),
                {27'd0, serialout, busy, done, underrun, tx_ready}, 32'd1);
        end
        @(posedge clk); #1;
        pay[0] = 8'h96; offer[0] = 0;
        run_scn(1);

        // Randomized byte counts, payloads and offer schedules.
        for (int it = 0; it < 12; it++) begin
            n = $urandom_range(1, MAXN);
            offer[0] = 0;
            for (int j = 0; j < n; j++) begin
                pay[j] = 8'($urandom);
                if (j > 0) begin
                    case ($urandom_range(0, 3))
                        0:       d = $urandom_range(1, 3);
                        1:       d = $urandom_range(30, 60);
                        2:       d = $urandom_range(95, 110);
                        default: d = $urandom_range(1, 140);
                    endcase
                    offer[j] = offer[j-1] + d;
                end
            end
            run_scn(n);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ask_tx.md
Name: ask_tx

Overview:
- Frame serializer feeding the ASK receiver input: takes a stream of bytes over a valid/ready handshake and emits one on-air frame on a single serial line.
- Frame: preamble at one bit per clk, then syncword and payload at one symbol per SYMBCLK_PRESCALER clks.
- Each payload byte is followed by BYTE_GAP zero symbols, which matches the receiver's byte cadence of PACKLEN+1 symbols.
- Sits between the host/packet source and the RF modulator pin.

Parameters:
PREAMBLE_WIDTH, 32, preamble length in clk cycles (1 bit per clk)
PREAMBLE, 32'hF0F0F0F0, preamble pattern, sent MSB first
SYNCWORD_WIDTH, 8, syncword length in symbols
SYNCWORD, 8'b11100101, syncword pattern, sent MSB first
SYMBCLK_PRESCALER, 4, clk cycles per symbol (>=2)
PACKLEN, 8, payload bits per byte
BYTE_GAP, 1, zero symbols after every payload byte (>=1)

Ports:
clk  input  1  system/sample clock, all logic on posedge
reset  input  1  asynchronous, active-low reset
tx_data  input  PACKLEN  payload byte
tx_valid  input  1  tx_data/tx_last valid
tx_last  input  1  byte is last of frame
tx_ready  output  1  block accepts byte this cycle (transfer = tx_valid & tx_ready)
serialout  output  1  registered ASK bit stream
busy  output  1  frame in progress (state != IDLE)
done  output  1  one-clk pulse when the last gap of a frame completes
underrun  output  1  one-clk pulse when a frame is aborted for lack of data

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; serialout=0, tx_ready=0 during reset; busy=0, done=0, underrun=0; hold buffer empty; all counters 0. Reset mid-frame aborts immediately: line goes to 0, no done/underrun pulse.
- Storage: current register (byte being shifted) plus a one-deep next buffer with last flag. A flag last_taken is set once a byte with tx_last=1 is accepted.
- tx_ready = (state==IDLE) | (state in {SYNC,DATA,GAP} & next buffer empty & !last_taken). This is combinational from registered state.
- FSM:
  - IDLE: serialout=0. A transfer loads the current register and last flag, clears counters, and moves to PREAMBLE. serialout = PREAMBLE[PREAMBLE_WIDTH-1] on the clk after the transfer (latency 1).
  - PREAMBLE: PREAMBLE_WIDTH clks, one bit per clk, MSB first. Then SYNC.
  - SYNC: SYNCWORD_WIDTH symbols, each held exactly SYMBCLK_PRESCALER clks, MSB first. Then DATA.
  - DATA: PACKLEN symbols of the current byte, MSB first. Then GAP.
  - GAP: BYTE_GAP symbols of 0. On the final clk of GAP, exactly one of the following applies:
    - current byte was last: go to IDLE and pulse done.
    - next buffer full: move it into current and go to DATA. The next symbol is a DATA bit with no extra idle.
    - otherwise: go to IDLE, pulse underrun, clear last_taken.
- A transfer in the final GAP clk is accepted and fills the buffer in time for DATA; that is not an underrun.
- Symbol counter: 0..SYMBCLK_PRESCALER-1, wraps. Bit index advances only on wrap. Width is $clog2 of the relevant length +1.
- Frame length in clks for N bytes: PREAMBLE_WIDTH + SYMBCLK_PRESCALER*(SYNCWORD_WIDTH + N*(PACKLEN+BYTE_GAP)). With defaults and N=1 this is 100 clks.
- busy is 1 from the clk after the accepting transfer through the last GAP clk. done/underrun assert on the clk busy falls.
- tx_valid while tx_ready=0: ignored, no state change. tx_data is sampled only on a transfer.
- After done, IDLE accepts a new frame on the very next clk (tx_ready=1).

Test Plan:
- Reset then a single byte 8'hA5 with tx_last=1: serialout is 0xF0F0F0F0 one bit per clk, then 11100101 and 10100101 four clks per bit, then 4 clks of 0. done pulses at clk 100, then idle at 0.
- Three bytes 8'h01, 8'hFF, 8'h80 (last) with tx_valid held high: tx_ready accepts each once. Frame is 32+4*(8+27)=172 clks, contiguous DATA/GAP, done once, no underrun.
- Two-byte frame where the second byte is offered only after the first GAP ends: underrun pulses at clk 32+4*(8+9)=100, busy drops, and the late byte starts a new frame (tx_ready=1 in IDLE).
- Second byte presented exactly on the final GAP clk: accepted, DATA follows with no idle symbol, no underrun.
- Reset asserted mid-SYNC: serialout=0, busy=0, tx_ready=0 immediately (asynchronous). After release the block is in IDLE with the buffer empty and no done pulse.
- Loopback into the ASK receiver with defaults, payload 8'h3C: the receiver reports synchronised and delivers data 8'h3C with a ready pulse.
